// File: rtl/equiv_pkg.sv
// Shared types and helpers for the equivalence-harness result monitor.
// Holds the FSM state type, the default harness width and the saturating increment.
package equiv_pkg;

  localparam int EQUIV_W = 91;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WARMUP = 2'd1,
    ST_CHECK  = 2'd2,
    ST_DONE   = 2'd3
  } equiv_state_e;

  // Increment v, holding at the all-ones value of a w-bit counter (w < 64).
  function automatic logic [63:0] sat_inc(input logic [63:0] v, input int unsigned w);
    logic [63:0] max_v;
    max_v = (64'd1 << w) - 64'd1;
    return (v >= max_v) ? v : v + 64'd1;
  endfunction

endpackage

// File: rtl/equiv_sat_counter.sv
// Saturating up-counter with synchronous reset and synchronous clear.
// clr has the same effect as rst; sat is high while the count is all ones.
module equiv_sat_counter
  import equiv_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             sat
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= CNT_W'(sat_inc(64'(cnt), CNT_W));
    end
  end

  assign sat = &cnt;

endmodule

// File: rtl/equiv_result_monitor.sv
// Compares the paired harness outputs over a bounded run and keeps a sticky verdict.
// Optional macro EQUIV_ASSERT_EN adds a formal assertion and a cover on the fail rise.
module equiv_result_monitor
  import equiv_pkg::*;
#(
  parameter int WIDTH   = EQUIV_W,
  parameter int WARMUP  = 4,
  parameter int RUN_LEN = 1024,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] y_1,
  input  logic [WIDTH-1:0] y_2,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic [CNT_W-1:0] first_fail_cycle,
  output logic [WIDTH-1:0] cap_y1,
  output logic [WIDTH-1:0] cap_y2,
  output equiv_state_e     state
);

  // The cycle index must reach both WARMUP-1 and RUN_LEN-1 even when CNT_W is
  // narrow; first_fail_cycle reports its low CNT_W bits.
  localparam int SPAN  = (WARMUP > RUN_LEN) ? WARMUP : RUN_LEN;
  localparam int IDX_W = ($clog2(SPAN + 1) > CNT_W) ? $clog2(SPAN + 1) : CNT_W;
  localparam logic [IDX_W-1:0] WARM_LAST = IDX_W'((WARMUP > 0) ? WARMUP - 1 : 0);
  localparam logic [IDX_W-1:0] RUN_LAST  = IDX_W'(RUN_LEN - 1);

  logic [IDX_W-1:0] idx;
  logic             idx_sat;
  logic             mis_sat;
  logic             can_start;
  logic             warm_end;
  logic             run_end;
  logic             mism;

  // start is a one-cycle request, accepted only from IDLE or DONE; there is no
  // ready/ack: a start seen in any other state is dropped.
  assign can_start = start && ((state == ST_IDLE) || (state == ST_DONE));
  assign warm_end  = (state == ST_WARMUP) && (idx == WARM_LAST);
  assign run_end   = (state == ST_CHECK) && (idx == RUN_LAST);
  assign mism      = (state == ST_CHECK) && (y_1 != y_2);

  assign busy = (state == ST_WARMUP) || (state == ST_CHECK);
  assign done = (state == ST_DONE);
  assign pass = done && (mismatch_cnt == '0);

  equiv_sat_counter #(.CNT_W(IDX_W)) u_idx_cnt (
    .clk (clk),
    .rst (rst),
    .clr (can_start || warm_end),
    .inc (busy && !idx_sat),
    .cnt (idx),
    .sat (idx_sat)
  );

  equiv_sat_counter #(.CNT_W(CNT_W)) u_mis_cnt (
    .clk (clk),
    .rst (rst),
    .clr (can_start),
    .inc (mism && !mis_sat),
    .cnt (mismatch_cnt),
    .sat (mis_sat)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: if (start) state <= (WARMUP == 0) ? ST_CHECK : ST_WARMUP;
        ST_WARMUP:        if (warm_end) state <= ST_CHECK;
        ST_CHECK:         if (run_end) state <= ST_DONE;
        default:          state <= ST_IDLE;
      endcase
    end
  end

  // Only the first counted mismatch is captured; later ones just bump the count.
  always_ff @(posedge clk) begin
    if (rst || can_start) begin
      fail             <= 1'b0;
      first_fail_cycle <= '0;
      cap_y1           <= '0;
      cap_y2           <= '0;
    end else if (mism && !fail) begin
      fail             <= 1'b1;
      first_fail_cycle <= idx[CNT_W-1:0];
      cap_y1           <= y_1;
      cap_y2           <= y_2;
    end
  end

`ifdef EQUIV_ASSERT_EN
  always_ff @(posedge clk) begin
    if (!rst && (state == ST_CHECK)) begin
      assert (y_1 == y_2);
    end
  end

  cover property (@(posedge clk) disable iff (rst) $rose(fail));
`endif

endmodule

// File: tb/tb_equiv_result_monitor.sv
// Directed bench for equiv_result_monitor: one instance at the default width with
// WARMUP=4/RUN_LEN=8, and a narrow-counter instance with WARMUP=0/RUN_LEN=10/CNT_W=3.
module tb_equiv_result_monitor;
  import equiv_pkg::*;

  localparam int W = 91;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         a_start = 1'b0, b_start = 1'b0;
  logic [W-1:0] a_y1 = '0, a_y2 = '0, b_y1 = '0, b_y2 = '0;
  logic         a_busy, a_done, a_pass, a_fail;
  logic         b_busy, b_done, b_pass, b_fail;
  logic [15:0]  a_mis, a_ffc;
  logic [2:0]   b_mis, b_ffc;
  logic [W-1:0] a_cap1, a_cap2, b_cap1, b_cap2;
  equiv_state_e a_state, b_state;

  int total = 0;
  int bad = 0;
  logic [W-1:0] exp_q[$];

  always #5 clk = ~clk;

  equiv_result_monitor #(.WIDTH(W), .WARMUP(4), .RUN_LEN(8), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .start(a_start), .y_1(a_y1), .y_2(a_y2),
    .busy(a_busy), .done(a_done), .pass(a_pass), .fail(a_fail),
    .mismatch_cnt(a_mis), .first_fail_cycle(a_ffc),
    .cap_y1(a_cap1), .cap_y2(a_cap2), .state(a_state)
  );

  equiv_result_monitor #(.WIDTH(W), .WARMUP(0), .RUN_LEN(10), .CNT_W(3)) dut_b (
    .clk(clk), .rst(rst), .start(b_start), .y_1(b_y1), .y_2(b_y2),
    .busy(b_busy), .done(b_done), .pass(b_pass), .fail(b_fail),
    .mismatch_cnt(b_mis), .first_fail_cycle(b_ffc),
    .cap_y1(b_cap1), .cap_y2(b_cap2), .state(b_state)
  );

  function automatic logic [W-1:0] rand_w();
    return W'({$urandom(), $urandom(), $urandom()});
  endfunction

  task automatic test_reset();
    rst = 1'b1; a_start = 1'b1; b_start = 1'b1;
    for (int i = 0; i < 2; i++) begin
      a_y1 = rand_w(); a_y2 = rand_w(); b_y1 = rand_w(); b_y2 = rand_w();
      @(negedge clk);
    end
    total++; if (a_state !== ST_IDLE) begin bad++; $display("FAIL rst_state got=%0d exp=0", a_state); end
    total++; if (a_busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%0b exp=0", a_busy); end
    total++; if (a_done !== 1'b0) begin bad++; $display("FAIL rst_done got=%0b exp=0", a_done); end
    total++; if (a_pass !== 1'b0) begin bad++; $display("FAIL rst_pass got=%0b exp=0", a_pass); end
    total++; if (a_fail !== 1'b0) begin bad++; $display("FAIL rst_fail got=%0b exp=0", a_fail); end
    total++; if (a_mis !== 16'd0) begin bad++; $display("FAIL rst_mis got=%0d exp=0", a_mis); end
    total++; if (a_ffc !== 16'd0) begin bad++; $display("FAIL rst_ffc got=%0d exp=0", a_ffc); end
    total++; if (a_cap1 !== '0) begin bad++; $display("FAIL rst_cap1 got=%0h exp=0", a_cap1); end
    total++; if (a_cap2 !== '0) begin bad++; $display("FAIL rst_cap2 got=%0h exp=0", a_cap2); end
    total++; if (b_state !== ST_IDLE) begin bad++; $display("FAIL rst_b_state got=%0d exp=0", b_state); end
    total++; if (b_mis !== 3'd0) begin bad++; $display("FAIL rst_b_mis got=%0d exp=0", b_mis); end
    rst = 1'b0; a_start = 1'b0; b_start = 1'b0;
    @(negedge clk);
    total++; if (a_state !== ST_IDLE) begin bad++; $display("FAIL idle_hold got=%0d exp=0", a_state); end
  endtask

  task automatic test_clean_run();
    int n;
    logic [W-1:0] v;
    a_start = 1'b1; @(negedge clk); a_start = 1'b0;
    n = 0;
    while (a_busy === 1'b1 && n < 50) begin
      v = rand_w(); a_y1 = v; a_y2 = v;
      n++; @(negedge clk);
    end
    total++; if (n !== 12) begin bad++; $display("FAIL clean_len got=%0d exp=12", n); end
    total++; if (a_done !== 1'b1) begin bad++; $display("FAIL clean_done got=%0b exp=1", a_done); end
    total++; if (a_pass !== 1'b1) begin bad++; $display("FAIL clean_pass got=%0b exp=1", a_pass); end
    total++; if (a_fail !== 1'b0) begin bad++; $display("FAIL clean_fail got=%0b exp=0", a_fail); end
    total++; if (a_mis !== 16'd0) begin bad++; $display("FAIL clean_mis got=%0d exp=0", a_mis); end
  endtask

  task automatic test_warmup_mask();
    int n;
    logic [W-1:0] v;
    a_start = 1'b1; @(negedge clk); a_start = 1'b0;
    n = 0;
    while (a_busy === 1'b1 && n < 50) begin
      v = rand_w(); a_y1 = v; a_y2 = (n < 4) ? ~v : v;
      n++; @(negedge clk);
    end
    total++; if (n !== 12) begin bad++; $display("FAIL warm_len got=%0d exp=12", n); end
    total++; if (a_pass !== 1'b1) begin bad++; $display("FAIL warm_pass got=%0b exp=1", a_pass); end
    total++; if (a_mis !== 16'd0) begin bad++; $display("FAIL warm_mis got=%0d exp=0", a_mis); end
  endtask

  task automatic test_first_fail();
    int n;
    logic [W-1:0] v;
    exp_q.push_back(W'(1));
    exp_q.push_back(W'(0));
    a_start = 1'b1; @(negedge clk); a_start = 1'b0;
    n = 0;
    while (a_busy === 1'b1 && n < 50) begin
      if (n == 7) begin
        total++; if (a_fail !== 1'b0) begin bad++; $display("FAIL ff_early got=%0b exp=0", a_fail); end
      end
      if (n == 8) begin
        total++; if (a_fail !== 1'b1) begin bad++; $display("FAIL ff_latency got=%0b exp=1", a_fail); end
        total++; if (a_mis !== 16'd1) begin bad++; $display("FAIL ff_mis1 got=%0d exp=1", a_mis); end
      end
      v = rand_w(); a_y1 = v; a_y2 = v;
      if (n == 7) begin a_y1 = W'(1); a_y2 = W'(0); end
      if (n == 10) a_y2 = ~v;
      a_start = (n == 5) || (n == 11);
      n++; @(negedge clk);
    end
    a_start = 1'b0;
    total++; if (n !== 12) begin bad++; $display("FAIL ff_len got=%0d exp=12", n); end
    total++; if (a_mis !== 16'd2) begin bad++; $display("FAIL ff_mis got=%0d exp=2", a_mis); end
    total++; if (a_ffc !== 16'd3) begin bad++; $display("FAIL ff_cycle got=%0d exp=3", a_ffc); end
    v = exp_q.pop_front();
    total++; if (a_cap1 !== v) begin bad++; $display("FAIL ff_cap1 got=%0h exp=%0h", a_cap1, v); end
    v = exp_q.pop_front();
    total++; if (a_cap2 !== v) begin bad++; $display("FAIL ff_cap2 got=%0h exp=%0h", a_cap2, v); end
    total++; if (a_pass !== 1'b0) begin bad++; $display("FAIL ff_pass got=%0b exp=0", a_pass); end
    @(negedge clk);
    total++; if (a_state !== ST_DONE) begin bad++; $display("FAIL ff_last_start got=%0d exp=3", a_state); end
    total++; if (a_fail !== 1'b1) begin bad++; $display("FAIL ff_sticky got=%0b exp=1", a_fail); end
  endtask

  task automatic test_restart_from_done();
    int n;
    logic [W-1:0] v;
    a_y1 = '0; a_y2 = '0;
    a_start = 1'b1; @(negedge clk); a_start = 1'b0;
    total++; if (a_busy !== 1'b1) begin bad++; $display("FAIL rs_busy got=%0b exp=1", a_busy); end
    total++; if (a_done !== 1'b0) begin bad++; $display("FAIL rs_done got=%0b exp=0", a_done); end
    total++; if (a_fail !== 1'b0) begin bad++; $display("FAIL rs_fail got=%0b exp=0", a_fail); end
    total++; if (a_mis !== 16'd0) begin bad++; $display("FAIL rs_mis got=%0d exp=0", a_mis); end
    total++; if (a_ffc !== 16'd0) begin bad++; $display("FAIL rs_ffc got=%0d exp=0", a_ffc); end
    total++; if (a_cap1 !== '0) begin bad++; $display("FAIL rs_cap1 got=%0h exp=0", a_cap1); end
    total++; if (a_cap2 !== '0) begin bad++; $display("FAIL rs_cap2 got=%0h exp=0", a_cap2); end
    n = 0;
    while (a_busy === 1'b1 && n < 50) begin
      v = rand_w(); a_y1 = v; a_y2 = v;
      n++; @(negedge clk);
    end
    total++; if (n !== 12) begin bad++; $display("FAIL rs_len got=%0d exp=12", n); end
    total++; if (a_pass !== 1'b1) begin bad++; $display("FAIL rs_pass got=%0b exp=1", a_pass); end
  endtask

  task automatic test_mid_run_reset();
    logic [W-1:0] v;
    a_start = 1'b1; @(negedge clk); a_start = 1'b0;
    for (int n = 0; n < 5; n++) begin
      v = rand_w(); a_y1 = v; a_y2 = (n == 4) ? ~v : v;
      @(negedge clk);
    end
    total++; if (a_fail !== 1'b1) begin bad++; $display("FAIL mr_fail_pre got=%0b exp=1", a_fail); end
    total++; if (a_mis !== 16'd1) begin bad++; $display("FAIL mr_mis_pre got=%0d exp=1", a_mis); end
    rst = 1'b1; a_start = 1'b1; @(negedge clk);
    rst = 1'b0; a_start = 1'b0;
    total++; if (a_state !== ST_IDLE) begin bad++; $display("FAIL mr_state got=%0d exp=0", a_state); end
    total++; if (a_fail !== 1'b0) begin bad++; $display("FAIL mr_fail got=%0b exp=0", a_fail); end
    total++; if (a_mis !== 16'd0) begin bad++; $display("FAIL mr_mis got=%0d exp=0", a_mis); end
    total++; if (a_cap1 !== '0) begin bad++; $display("FAIL mr_cap1 got=%0h exp=0", a_cap1); end
    total++; if (a_busy !== 1'b0) begin bad++; $display("FAIL mr_busy got=%0b exp=0", a_busy); end
    repeat (2) @(negedge clk);
    total++; if (a_state !== ST_IDLE) begin bad++; $display("FAIL mr_idle got=%0d exp=0", a_state); end
  endtask

  task automatic test_saturation();
    int n;
    logic [W-1:0] v;
    exp_q.push_back(W'(5));
    v = W'(5);
    exp_q.push_back(~v);
    b_start = 1'b1; @(negedge clk); b_start = 1'b0;
    total++; if (b_state !== ST_CHECK) begin bad++; $display("FAIL sat_nowarm got=%0d exp=2", b_state); end
    n = 0;
    while (b_busy === 1'b1 && n < 50) begin
      if (n == 1) begin
        total++; if (b_mis !== 3'd1) begin bad++; $display("FAIL sat_mis1 got=%0d exp=1", b_mis); end
      end
      b_y1 = W'(n) + W'(5); b_y2 = ~b_y1;
      n++; @(negedge clk);
    end
    total++; if (n !== 10) begin bad++; $display("FAIL sat_len got=%0d exp=10", n); end
    total++; if (b_mis !== 3'd7) begin bad++; $display("FAIL sat_mis got=%0d exp=7", b_mis); end
    total++; if (b_ffc !== 3'd0) begin bad++; $display("FAIL sat_ffc got=%0d exp=0", b_ffc); end
    total++; if (b_fail !== 1'b1) begin bad++; $display("FAIL sat_fail got=%0b exp=1", b_fail); end
    total++; if (b_done !== 1'b1) begin bad++; $display("FAIL sat_done got=%0b exp=1", b_done); end
    total++; if (b_pass !== 1'b0) begin bad++; $display("FAIL sat_pass got=%0b exp=0", b_pass); end
    v = exp_q.pop_front();
    total++; if (b_cap1 !== v) begin bad++; $display("FAIL sat_cap1 got=%0h exp=%0h", b_cap1, v); end
    v = exp_q.pop_front();
    total++; if (b_cap2 !== v) begin bad++; $display("FAIL sat_cap2 got=%0h exp=%0h", b_cap2, v); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_clean_run();
    test_warmup_mask();
    test_first_fail();
    test_restart_from_done();
    test_mid_run_reset();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
